// File: rtl/c7bbiu_arb.sv
// rtl/c7bbiu_arb.sv - IFU/LSU bus interface arbiter with a single outstanding memory transaction
//
// Ports:
//   clk, resetn                 clock (rising edge), asynchronous active-low reset
//   ifu_biu_req/addr            instruction fetch request, held until biu_ifu_ack
//   biu_ifu_ack/data_valid      fetch address accepted / fetch data valid (1-cycle pulses)
//   lsu_biu_req/we/addr/wdata/wstrb  load-store request, held until biu_lsu_ack
//   biu_lsu_ack/data_valid      LSU address accepted / read data or write response (1-cycle pulses)
//   biu_rdata                   read data for both requesters, straight from mem_biu_rdata
//   biu_mem_req/we/addr/wdata/wstrb  registered memory request channel
//   mem_biu_ack/valid/rdata     memory address accept / response channel
//   biu_busy                    a transaction is in flight (state is not IDLE)
module c7bbiu_arb #(
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ifu_biu_req,
  input  logic [31:0] ifu_biu_addr,
  output logic        biu_ifu_ack,
  output logic        biu_ifu_data_valid,
  input  logic        lsu_biu_req,
  input  logic        lsu_biu_we,
  input  logic [31:0] lsu_biu_addr,
  input  logic [31:0] lsu_biu_wdata,
  input  logic [3:0]  lsu_biu_wstrb,
  output logic        biu_lsu_ack,
  output logic        biu_lsu_data_valid,
  output logic [31:0] biu_rdata,
  output logic        biu_mem_req,
  output logic        biu_mem_we,
  output logic [31:0] biu_mem_addr,
  output logic [31:0] biu_mem_wdata,
  output logic [3:0]  biu_mem_wstrb,
  input  logic        mem_biu_ack,
  input  logic        mem_biu_valid,
  input  logic [31:0] mem_biu_rdata,
  output logic        biu_busy
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        owner_lsu;   // 1: LSU owns the in-flight transaction, 0: IFU
  logic [3:0]  starve_cnt;  // LSU grants issued while the IFU was kept waiting
  logic        grant_lsu;
  logic        grant_ifu;

  // LSU has priority unless the IFU has already been passed over STARVE_MAX times.
  always_comb begin
    grant_lsu = lsu_biu_req && !(ifu_biu_req && (starve_cnt == STARVE_LIM));
    grant_ifu = ifu_biu_req && !grant_lsu;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_lsu || grant_ifu) state_nxt = ADDR;
      ADDR:    if (mem_biu_ack)            state_nxt = DATA;
      DATA:    if (mem_biu_valid)          state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // Request channel and grant bookkeeping; fields are captured only in IDLE,
  // so requester inputs are ignored for the rest of the transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_lsu     <= 1'b0;
      starve_cnt    <= 4'd0;
      biu_mem_req   <= 1'b0;
      biu_mem_we    <= 1'b0;
      biu_mem_addr  <= 32'd0;
      biu_mem_wdata <= 32'd0;
      biu_mem_wstrb <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_lsu) begin
            owner_lsu     <= 1'b1;
            biu_mem_req   <= 1'b1;
            biu_mem_we    <= lsu_biu_we;
            biu_mem_addr  <= lsu_biu_addr;
            biu_mem_wdata <= lsu_biu_wdata;
            biu_mem_wstrb <= lsu_biu_wstrb;
            if (ifu_biu_req && (starve_cnt < STARVE_LIM)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else if (grant_ifu) begin
            owner_lsu     <= 1'b0;
            biu_mem_req   <= 1'b1;
            biu_mem_we    <= 1'b0;
            biu_mem_addr  <= ifu_biu_addr;
            biu_mem_wdata <= 32'd0;
            biu_mem_wstrb <= 4'd0;
            starve_cnt    <= 4'd0;
          end
        end
        ADDR: begin
          if (mem_biu_ack) begin
            biu_mem_req <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Acks and data_valids are the memory strobes qualified by state and owner,
  // which also makes stray strobes in the wrong state invisible.
  always_comb begin
    biu_busy           = (state != IDLE);
    biu_ifu_ack        = 1'b0;
    biu_lsu_ack        = 1'b0;
    biu_ifu_data_valid = 1'b0;
    biu_lsu_data_valid = 1'b0;
    if (state == ADDR) begin
      biu_ifu_ack = mem_biu_ack && !owner_lsu;
      biu_lsu_ack = mem_biu_ack &&  owner_lsu;
    end
    if (state == DATA) begin
      biu_ifu_data_valid = mem_biu_valid && !owner_lsu;
      biu_lsu_data_valid = mem_biu_valid &&  owner_lsu;
    end
  end

  assign biu_rdata = mem_biu_rdata;

endmodule

// File: tb/tb_c7bbiu_arb.sv
// tb/tb_c7bbiu_arb.sv - scoreboard testbench for c7bbiu_arb
module tb_c7bbiu_arb;

  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ifu_biu_req;
  logic [31:0] ifu_biu_addr;
  logic        biu_ifu_ack;
  logic        biu_ifu_data_valid;
  logic        lsu_biu_req;
  logic        lsu_biu_we;
  logic [31:0] lsu_biu_addr;
  logic [31:0] lsu_biu_wdata;
  logic [3:0]  lsu_biu_wstrb;
  logic        biu_lsu_ack;
  logic        biu_lsu_data_valid;
  logic [31:0] biu_rdata;
  logic        biu_mem_req;
  logic        biu_mem_we;
  logic [31:0] biu_mem_addr;
  logic [31:0] biu_mem_wdata;
  logic [3:0]  biu_mem_wstrb;
  logic        mem_biu_ack;
  logic        mem_biu_valid;
  logic [31:0] mem_biu_rdata;
  logic        biu_busy;

  always #5 clk = ~clk;

  c7bbiu_arb #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .ifu_biu_req        (ifu_biu_req),
    .ifu_biu_addr       (ifu_biu_addr),
    .biu_ifu_ack        (biu_ifu_ack),
    .biu_ifu_data_valid (biu_ifu_data_valid),
    .lsu_biu_req        (lsu_biu_req),
    .lsu_biu_we         (lsu_biu_we),
    .lsu_biu_addr       (lsu_biu_addr),
    .lsu_biu_wdata      (lsu_biu_wdata),
    .lsu_biu_wstrb      (lsu_biu_wstrb),
    .biu_lsu_ack        (biu_lsu_ack),
    .biu_lsu_data_valid (biu_lsu_data_valid),
    .biu_rdata          (biu_rdata),
    .biu_mem_req        (biu_mem_req),
    .biu_mem_we         (biu_mem_we),
    .biu_mem_addr       (biu_mem_addr),
    .biu_mem_wdata      (biu_mem_wdata),
    .biu_mem_wstrb      (biu_mem_wstrb),
    .mem_biu_ack        (mem_biu_ack),
    .mem_biu_valid      (mem_biu_valid),
    .mem_biu_rdata      (mem_biu_rdata),
    .biu_busy           (biu_busy)
  );

  typedef struct {
    logic        lsu;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t dv_q[$];
  txn_t mon_e;
  txn_t mon_d;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ack    = 0;
  int since_dv = 100;
  logic prev_req = 1'b0;

  logic mem_auto  = 1'b1;
  int   ack_dly   = 0;
  int   valid_dly = 1;
  int   mst       = 0;
  int   mcnt      = 0;

  logic ifu_keep = 1'b0;
  logic lsu_keep = 1'b0;
  logic ifu_ack_seen = 1'b0;
  logic lsu_ack_seen = 1'b0;

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    if (a == 32'h1C00_0000) return 32'h0280_0000;
    return ~a ^ 32'h1357_9BDF;
  endfunction

  function automatic txn_t mk(input logic lsu, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb);
    txn_t t;
    t.lsu = lsu; t.we = we; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb;
    t.rdata = rdata_for(addr);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: ack ack_dly cycles after seeing a request, data valid_dly cycles after ack.
  initial begin
    mem_biu_ack = 1'b0; mem_biu_valid = 1'b0; mem_biu_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_auto) begin
        mst = 0;
      end else begin
        mem_biu_ack = 1'b0;
        mem_biu_valid = 1'b0;
        if (mst == 0 && biu_mem_req) begin mst = 1; mcnt = ack_dly; end
        if (mst == 1) begin
          if (mcnt == 0) begin mem_biu_ack = 1'b1; mst = 2; mcnt = valid_dly; end
          else mcnt--;
        end else if (mst == 2) begin
          if (mcnt <= 1) begin
            mem_biu_valid = 1'b1;
            mem_biu_rdata = rdata_for(biu_mem_addr);
            mst = 0;
          end else mcnt--;
        end
      end
    end
  end

  // Requesters drop their request after the ack unless told to keep requesting.
  always @(posedge clk) begin
    #1;
    if (ifu_ack_seen) begin ifu_ack_seen = 1'b0; if (!ifu_keep) ifu_biu_req = 1'b0; end
    if (lsu_ack_seen) begin lsu_ack_seen = 1'b0; if (!lsu_keep) lsu_biu_req = 1'b0; end
  end

  // Scoreboard monitor: grants popped at ack, responses popped at data_valid.
  always @(negedge clk) begin
    if (biu_ifu_ack || biu_lsu_ack) begin
      n_ack++;
      n_checks++;
      if (biu_ifu_ack) ifu_ack_seen = 1'b1;
      if (biu_lsu_ack) lsu_ack_seen = 1'b1;
      if (biu_ifu_ack && biu_lsu_ack) begin
        n_fail++;
        $display("FAIL ack_exclusive: both acks high, expected at most one");
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ack_unexpected: lsu_ack=%0b addr=%h, expected no ack", biu_lsu_ack, biu_mem_addr);
      end else begin
        mon_e = exp_q.pop_front();
        if (biu_lsu_ack !== mon_e.lsu || biu_mem_we !== mon_e.we || biu_mem_addr !== mon_e.addr ||
            biu_mem_wstrb !== mon_e.wstrb || (mon_e.we && biu_mem_wdata !== mon_e.wdata)) begin
          n_fail++;
          $display("FAIL ack_grant: got lsu=%0b we=%0b addr=%h wdata=%h wstrb=%h, expected lsu=%0b we=%0b addr=%h wdata=%h wstrb=%h",
                   biu_lsu_ack, biu_mem_we, biu_mem_addr, biu_mem_wdata, biu_mem_wstrb,
                   mon_e.lsu, mon_e.we, mon_e.addr, mon_e.wdata, mon_e.wstrb);
        end
        dv_q.push_back(mon_e);
      end
    end
    if (biu_ifu_data_valid || biu_lsu_data_valid) begin
      n_checks++;
      if (biu_ifu_data_valid && biu_lsu_data_valid) begin
        n_fail++;
        $display("FAIL dv_exclusive: both data_valids high, expected at most one");
      end else if (dv_q.size() == 0) begin
        n_fail++;
        $display("FAIL dv_unexpected: lsu_dv=%0b rdata=%h, expected no data_valid", biu_lsu_data_valid, biu_rdata);
      end else begin
        mon_d = dv_q.pop_front();
        if (biu_lsu_data_valid !== mon_d.lsu || (!mon_d.we && biu_rdata !== mon_d.rdata)) begin
          n_fail++;
          $display("FAIL dv_data: got lsu=%0b rdata=%h, expected lsu=%0b rdata=%h",
                   biu_lsu_data_valid, biu_rdata, mon_d.lsu, mon_d.rdata);
        end
      end
      since_dv = 0;
    end else if (since_dv < 100) begin
      since_dv++;
    end
    if (biu_mem_req && !prev_req && since_dv < 100) begin
      n_checks++;
      if (since_dv < 2) begin
        n_fail++;
        $display("FAIL req_spacing: request %0d cycles after data_valid, expected >= 2", since_dv);
      end
    end
    prev_req = biu_mem_req;
  end

  task automatic wait_done(input string name);
    int c = 0;
    while ((exp_q.size() != 0 || dv_q.size() != 0 || biu_busy) && c < 300) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (c >= 300) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d grants, %0d responses pending, expected 0", name, exp_q.size(), dv_q.size());
    end
    tick();
  endtask

  task automatic wait_acks(input int target, input string name);
    int c = 0;
    while (n_ack < target && c < 300) begin
      @(negedge clk);
      #1;
      c++;
    end
    n_checks++;
    if (c >= 300) begin
      n_fail++;
      $display("FAIL %s_ack_timeout: %0d acks seen, expected %0d", name, n_ack, target);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    ifu_biu_req = 1'b0; ifu_biu_addr = 32'd0;
    lsu_biu_req = 1'b0; lsu_biu_we = 1'b0; lsu_biu_addr = 32'd0;
    lsu_biu_wdata = 32'd0; lsu_biu_wstrb = 4'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({biu_mem_req, biu_mem_we, biu_mem_addr, biu_mem_wdata, biu_mem_wstrb, biu_busy,
         biu_ifu_ack, biu_lsu_ack, biu_ifu_data_valid, biu_lsu_data_valid} !== 76'd0) begin
      n_fail++;
      $display("FAIL reset_state: req=%0b we=%0b addr=%h wdata=%h wstrb=%h busy=%0b, expected all 0",
               biu_mem_req, biu_mem_we, biu_mem_addr, biu_mem_wdata, biu_mem_wstrb, biu_busy);
    end
    tick();
    lsu_biu_req = 1'b1; lsu_biu_we = 1'b0; lsu_biu_addr = 32'h0000_0100;
    exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_0100, 32'd0, 4'd0));
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_checks++;
    if (biu_mem_req !== 1'b0 || biu_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_early_grant: req=%0b busy=%0b, expected 0 0", biu_mem_req, biu_busy);
    end
    @(negedge clk);
    n_checks++;
    if (biu_mem_req !== 1'b1 || biu_mem_addr !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL reset_first_grant: req=%0b addr=%h, expected 1 00000100", biu_mem_req, biu_mem_addr);
    end
    wait_done("reset");
  endtask

  task automatic test_ifu_read();
    ack_dly = 2; valid_dly = 3;
    ifu_biu_req = 1'b1; ifu_biu_addr = 32'h1C00_0000;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h1C00_0000, 32'd0, 4'd0));
    @(negedge clk);
    n_checks++;
    if (biu_mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ifu_latency_early: req=%0b, expected 0", biu_mem_req);
    end
    @(negedge clk);
    n_checks++;
    if (biu_mem_req !== 1'b1 || biu_mem_addr !== 32'h1C00_0000 || biu_mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL ifu_grant: req=%0b addr=%h we=%0b, expected 1 1c000000 0", biu_mem_req, biu_mem_addr, biu_mem_we);
    end
    wait_done("ifu_read");
  endtask

  task automatic test_simultaneous();
    ack_dly = 0; valid_dly = 1;
    ifu_biu_req = 1'b1; ifu_biu_addr = 32'h1C00_0004;
    lsu_biu_req = 1'b1; lsu_biu_we = 1'b1; lsu_biu_addr = 32'h0000_1000;
    lsu_biu_wdata = 32'hDEAD_BEEF; lsu_biu_wstrb = 4'hF;
    exp_q.push_back(mk(1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h1C00_0004, 32'd0, 4'd0));
    wait_done("simultaneous");
  endtask

  task automatic test_starvation();
    int base;
    tick(); resetn = 1'b0; tick(); tick(); resetn = 1'b1; tick();
    ack_dly = 1; valid_dly = 1;
    base = n_ack;
    ifu_keep = 1'b1; lsu_keep = 1'b1;
    lsu_biu_we = 1'b0; lsu_biu_addr = 32'h0000_2000; lsu_biu_wstrb = 4'h0;
    ifu_biu_addr = 32'h1C00_0008;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_2000, 32'd0, 4'd0));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h1C00_0008, 32'd0, 4'd0));
    exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_2000, 32'd0, 4'd0));
    ifu_biu_req = 1'b1; lsu_biu_req = 1'b1;
    wait_acks(base + 3, "starve");
    ifu_keep = 1'b0;
    wait_acks(base + 4, "starve");
    lsu_keep = 1'b0;
    wait_done("starvation");
  endtask

  task automatic test_addr_hold();
    ack_dly = 4; valid_dly = 2;
    ifu_biu_req = 1'b1; ifu_biu_addr = 32'h1C00_0000;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h1C00_0000, 32'd0, 4'd0));
    tick();
    ifu_biu_addr = 32'h1C00_0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (biu_mem_addr !== 32'h1C00_0000 || biu_mem_req !== 1'b1) begin
        n_fail++;
        $display("FAIL addr_hold_%0d: req=%0b addr=%h, expected 1 1c000000", i, biu_mem_req, biu_mem_addr);
      end
    end
    wait_done("addr_hold");
  endtask

  task automatic test_stray();
    mem_auto = 1'b0;
    tick();
    mem_biu_valid = 1'b1; mem_biu_rdata = 32'h5555_AAAA;
    @(negedge clk);
    n_checks++;
    if (biu_ifu_data_valid !== 1'b0 || biu_lsu_data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_valid_idle: dv=%0b%0b, expected 00", biu_ifu_data_valid, biu_lsu_data_valid);
    end
    tick();
    mem_biu_valid = 1'b0; mem_biu_ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if (biu_ifu_ack !== 1'b0 || biu_lsu_ack !== 1'b0 || biu_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ack_idle: acks=%0b%0b busy=%0b, expected 00 0", biu_ifu_ack, biu_lsu_ack, biu_busy);
    end
    tick();
    mem_biu_ack = 1'b0;
    lsu_biu_req = 1'b1; lsu_biu_we = 1'b0; lsu_biu_addr = 32'h0000_3000; lsu_biu_wstrb = 4'h0;
    exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_3000, 32'd0, 4'd0));
    tick();
    mem_biu_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (biu_ifu_data_valid !== 1'b0 || biu_lsu_data_valid !== 1'b0 || biu_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_valid_addr: dv=%0b%0b busy=%0b, expected 00 1", biu_ifu_data_valid, biu_lsu_data_valid, biu_busy);
    end
    tick();
    mem_biu_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (biu_mem_req !== 1'b1 || biu_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_state_addr: req=%0b busy=%0b, expected 1 1", biu_mem_req, biu_busy);
    end
    tick();
    mem_biu_ack = 1'b1;
    tick();
    mem_biu_ack = 1'b0;
    mem_biu_rdata = rdata_for(32'h0000_3000);
    mem_biu_valid = 1'b1;
    tick();
    mem_biu_valid = 1'b0;
    mem_auto = 1'b1;
    wait_done("stray");
  endtask

  task automatic test_reset_mid();
    mem_auto = 1'b0;
    lsu_biu_req = 1'b1; lsu_biu_we = 1'b0; lsu_biu_addr = 32'h0000_4000;
    exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_4000, 32'd0, 4'd0));
    tick();
    tick();
    mem_biu_ack = 1'b1;
    tick();
    mem_biu_ack = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({biu_mem_req, biu_mem_we, biu_mem_addr, biu_mem_wdata, biu_mem_wstrb, biu_busy,
         biu_ifu_ack, biu_lsu_ack, biu_ifu_data_valid, biu_lsu_data_valid} !== 76'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: req=%0b addr=%h busy=%0b, expected all 0", biu_mem_req, biu_mem_addr, biu_busy);
    end
    dv_q.delete();
    tick();
    tick();
    resetn = 1'b1;
    tick();
    mem_biu_rdata = 32'h7777_0000;
    mem_biu_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (biu_ifu_data_valid !== 1'b0 || biu_lsu_data_valid !== 1'b0 || biu_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_stray: dv=%0b%0b busy=%0b, expected 00 0", biu_ifu_data_valid, biu_lsu_data_valid, biu_busy);
    end
    tick();
    mem_biu_valid = 1'b0;
    mem_auto = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_simultaneous();
    test_starvation();
    test_addr_hold();
    test_stray();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0 || dv_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d grants, %0d responses left, expected 0 0", exp_q.size(), dv_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/c7bbiu_arb.md
C7BBIU_ARB -- requirements
Module: c7bbiu_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3, meaning consecutive LSU grants allowed while IFU waits (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ifu_biu_req  input  1  IFU fetch request, held high until ack.
REQ-005 SHALL have port ifu_biu_addr  input  32  IFU fetch address.
REQ-006 SHALL have port biu_ifu_ack  output  1  IFU address accepted, 1-cycle pulse.
REQ-007 SHALL have port biu_ifu_data_valid  output  1  IFU read data valid, 1-cycle pulse.
REQ-008 SHALL have port lsu_biu_req  input  1  LSU request, held high until ack.
REQ-009 SHALL have port lsu_biu_we  input  1  LSU write enable.
REQ-010 SHALL have port lsu_biu_addr  input  32  LSU address.
REQ-011 SHALL have port lsu_biu_wdata  input  32  LSU write data.
REQ-012 SHALL have port lsu_biu_wstrb  input  4  LSU byte strobes.
REQ-013 SHALL have port biu_lsu_ack  output  1  LSU address accepted, 1-cycle pulse.
REQ-014 SHALL have port biu_lsu_data_valid  output  1  LSU read data / write response valid, 1-cycle pulse.
REQ-015 SHALL have port biu_rdata  output  32  read data, shared by both requesters, equals mem_biu_rdata.
REQ-016 SHALL have ports biu_mem_req (1), biu_mem_we (1), biu_mem_addr (32), biu_mem_wdata (32), biu_mem_wstrb (4)  output  memory request channel, all registered.
REQ-017 SHALL have ports mem_biu_ack (1), mem_biu_valid (1), mem_biu_rdata (32)  input  memory response channel.
REQ-018 SHALL have port biu_busy  output  1  high when state is not IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, ADDR, DATA; exactly one memory transaction outstanding.
REQ-020 IDLE: if any request, SHALL grant, latch owner, addr, we, wdata, wstrb (IFU grant: we=0, wstrb=0) and go to ADDR; biu_mem_req asserts the next cycle (1-cycle grant latency).
REQ-021 Arbitration SHALL be LSU-priority, except IFU wins when IFU requests and starve count equals STARVE_MAX.
REQ-022 Starve count (4 bits) SHALL increment on each LSU grant while ifu_biu_req=1, clear on any IFU grant, saturate at STARVE_MAX.
REQ-023 ADDR: biu_mem_req and latched fields SHALL hold stable until mem_biu_ack; on ack, SHALL go to DATA and drop biu_mem_req next cycle.
REQ-024 biu_ifu_ack / biu_lsu_ack SHALL equal mem_biu_ack gated by state ADDR and owner, same cycle (combinational).
REQ-025 DATA: on mem_biu_valid, SHALL pulse owner's data_valid same cycle and return to IDLE; writes complete the same way.
REQ-026 Requester inputs SHALL be ignored after grant; changes to ifu_biu_addr etc. during ADDR/DATA have no effect.
REQ-027 mem_biu_valid in IDLE or ADDR and mem_biu_ack in IDLE or DATA SHALL be ignored (no output pulse, no state change).
REQ-028 Minimum spacing: after DATA completes, next biu_mem_req SHALL assert no earlier than 2 cycles later (IDLE + grant).
REQ-029 Simultaneous IFU and LSU requests in IDLE SHALL produce exactly one grant; loser stays pending without ack.
REQ-030 IFU fetch cancellation (flush) is owned by the fetch control unit; arbiter SHALL always deliver data_valid for a granted IFU transaction.
REQ-031 Never both biu_ifu_ack and biu_lsu_ack, nor both data_valid outputs, in one cycle.

Reset
REQ-032 On resetn=0, SHALL asynchronously enter IDLE, clear owner, starve count, biu_mem_req, biu_mem_we, biu_mem_addr, biu_mem_wdata, biu_mem_wstrb to 0; biu_busy, acks, data_valids 0.
REQ-033 Reset mid-transaction SHALL abandon the in-flight transaction; stray memory responses after reset fall under REQ-027.
REQ-034 First grant SHALL occur no earlier than the first rising edge after resetn deasserts.

Verification
REQ-035 IFU-only read: ifu req addr 0x1C000000, mem ack 2 cycles later, valid 3 cycles after ack, rdata 0x02800000 -> biu_mem_addr=0x1C000000 one cycle after req, biu_ifu_ack with mem ack, biu_ifu_data_valid with rdata 0x02800000.
REQ-036 Simultaneous IFU read 0x1C000004 and LSU write 0x00001000 data 0xDEADBEEF wstrb 0xF -> LSU first (biu_mem_we=1), IFU granted after LSU data_valid, no overlap.
REQ-037 Starvation, STARVE_MAX=3: LSU and IFU requesting continuously -> grant order LSU, LSU, LSU, IFU, LSU...
REQ-038 Requester changes ifu_biu_addr to 0x1C000100 during ADDR -> biu_mem_addr stays 0x1C000000 until completion.
REQ-039 Stray mem_biu_valid in IDLE and in ADDR -> no data_valid pulse, state unchanged.
REQ-040 resetn low during DATA -> all outputs 0 immediately, IDLE; later mem_biu_valid produces no pulse.
